round_sequencer: RTL

Game-flow controller sitting directly upstream of the hit checker. It picks the target lamp from a free-running LFSR and frames each round with `start_checks`. It runs the per-round reaction timer that raises `clock_done` and consumes the checker's `give_point`/`lose_point` results to keep score and lives. Each hit shortens the reaction window, down to a floor.

---
 rtl/game_pkg.sv | 28 ++
 rtl/lfsr16.sv | 21 ++
 rtl/round_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding, field widths,
// LFSR tap mask and the lamp-pick helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int LAMP_W  = 2;
  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;
  localparam int CNT_W   = 26;

  // x^16 + x^14 + x^13 + x^11, left-shift form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Never repeat the previous lamp: bump by one on a match.
  function automatic logic [LAMP_W-1:0] pick_lamp(
    input logic [LAMP_W-1:0] raw,
    input logic [LAMP_W-1:0] prev
  );
    return (raw == prev) ? raw + 1'b1 : raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advances every cycle.
// Ports: clk, rst (sync, active high), q = register state.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-flow controller: picks target lamp, frames rounds,
// times the reaction window, keeps score and lives.
// Ports: clk, rst (sync, active high), start_game,
//   give_point/lose_point (checker results) in;
//   random_num, start_checks, clock_done, score,
//   lives, game_over out (all registered).
module round_sequencer
  import game_pkg::*;
#(
  parameter int          TIMEOUT_INIT = 50_000_000,
  parameter int          TIMEOUT_MIN  = 12_500_000,
  parameter int          TIMEOUT_STEP = 2_500_000,
  parameter int          GAP_CYCLES   = 5_000_000,
  parameter int          LIVES_INIT   = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_game,
  input  logic               give_point,
  input  logic               lose_point,
  output logic [LAMP_W-1:0]  random_num,
  output logic               start_checks,
  output logic               clock_done,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam logic [CNT_W-1:0] T_INIT =
    CNT_W'(TIMEOUT_INIT);
  localparam logic [CNT_W-1:0] T_MIN =
    CNT_W'(TIMEOUT_MIN);
  localparam logic [CNT_W-1:0] T_STEP =
    CNT_W'(TIMEOUT_STEP);
  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LIVES_W-1:0] L_INIT =
    LIVES_W'(LIVES_INIT);

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   timeout;
  logic [CNT_W-1:0]   gap_cnt;
  logic               first_cyc;
  logic [15:0]        lfsr_q;
  logic               unused_lfsr;

  logic [CNT_W-1:0]   timeout_dec;
  logic [CNT_W-1:0]   timer_inc;
  logic [SCORE_W-1:0] score_inc;
  logic [LIVES_W-1:0] lives_dec;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low bits pick the lamp.
  assign unused_lfsr = ^lfsr_q[15:2];

  // Clamp is resolved before writeback; no underflow.
  always_comb begin
    timeout_dec = T_MIN;
    if (timeout >= T_MIN && (timeout - T_MIN) >= T_STEP) begin
      timeout_dec = timeout - T_STEP;
    end
  end

  assign timer_inc = timer + 1'b1;
  assign score_inc = (score == '1) ? score : score + 1'b1;
  assign lives_dec = lives - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      random_num   <= '0;
      start_checks <= 1'b0;
      clock_done   <= 1'b0;
      score        <= '0;
      lives        <= '0;
      game_over    <= 1'b0;
      timer        <= '0;
      timeout      <= T_INIT;
      gap_cnt      <= '0;
      first_cyc    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start_game) begin
            score     <= '0;
            lives     <= L_INIT;
            timeout   <= T_INIT;
            game_over <= 1'b0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt >= G_LAST) begin
            random_num   <= pick_lamp(lfsr_q[1:0],
                                      random_num);
            start_checks <= 1'b1;
            timer        <= '0;
            // Window of one cycle expires immediately.
            clock_done   <= (timeout <= 1);
            first_cyc    <= 1'b1;
            state        <= ST_PLAY;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_PLAY: begin
          first_cyc <= 1'b0;
          // Raise clock_done as timer reaches timeout-1,
          // so it is visible in PLAY cycle 'timeout'.
          if (!clock_done) begin
            timer <= timer_inc;
            if (timer_inc == timeout - 1'b1) begin
              clock_done <= 1'b1;
            end
          end
          // Checker results are stale in the first cycle.
          if (!first_cyc) begin
            if (give_point) begin
              score        <= score_inc;
              timeout      <= timeout_dec;
              start_checks <= 1'b0;
              clock_done   <= 1'b0;
              gap_cnt      <= '0;
              state        <= ST_GAP;
            end else if (lose_point) begin
              lives        <= lives_dec;
              start_checks <= 1'b0;
              clock_done   <= 1'b0;
              gap_cnt      <= '0;
              if (lives_dec == '0) begin
                game_over <= 1'b1;
                state     <= ST_OVER;
              end else begin
                state <= ST_GAP;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
